regfile_sb: RTL and testbench

- Parametrised successor to the core's integer register file.
- Integer register file with configurable XLEN, register count and read-port count.
- Synchronous posedge write with write-to-read bypass, optional hardwired-zero register 0.
- Integrated per-register busy scoreboard so the decode stage can detect RAW/WAW hazards for the pipelined NPC; a debug commit port drives the simulator DPI register mirror.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_scoreboard.sv | 64 ++++++
 rtl/regfile_sb.sv | 88 ++++++++
 tb/tb_regfile_sb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file.
// Address width derivation lives here so every block agrees on it.
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_ADDR = 0;

  function automatic int addr_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << w) < n) w++;
    return w;
  endfunction

  typedef logic [addr_w(NREGS_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]          xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking for RAW/WAW hazard detection.
// Issue sets, writeback clears, flush/reset clear everything.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS    = NREGS_DEF,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic              flush
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             zero_en;

  assign zero_en = (ZERO_REG != 0);

  // New producer wins over a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (iss_en && iss_rd == AW'(r))
          busy_d[r] = 1'b1;
        else if (wr_en && wr_addr == AW'(r))
          busy_d[r] = 1'b0;
      end
    end
    if (zero_en)
      busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rd_addr[k*AW +: AW];
    assign rd_busy[k] = busy_q[ra]
                      & ~(wr_en & (wr_addr == ra));
  end

  assign iss_ready = ~busy_q[iss_rd]
                   | (wr_en & (wr_addr == iss_rd))
                   | (zero_en & (iss_rd == AW'(ZERO_ADDR)));

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write bypass, busy scoreboard
// and a registered debug commit port.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NREGS    = NREGS_DEF,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic                flush,
  output logic                dbg_valid,
  output logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            dbg_valid_q;
  logic [AW-1:0]   dbg_addr_q;
  logic [XLEN-1:0] dbg_data_q;
  logic            zero_en;
  logic            wr_legal;

  assign zero_en  = (ZERO_REG != 0);
  assign wr_legal = wr_en
                  & ~(zero_en & (wr_addr == AW'(ZERO_ADDR)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        regs_q[r] <= '0;
      dbg_valid_q <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_data_q  <= '0;
    end else begin
      if (wr_legal)
        regs_q[wr_addr] <= wr_data;
      dbg_valid_q <= wr_legal;
      if (wr_legal) begin
        dbg_addr_q <= wr_addr;
        dbg_data_q <= wr_data;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rd_addr[k*AW +: AW];
    assign rd_data[k*XLEN +: XLEN] =
      (zero_en && ra == AW'(ZERO_ADDR)) ? '0 :
      (wr_legal && wr_addr == ra)       ? wr_data :
                                          regs_q[ra];
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .flush     (flush)
  );

  assign dbg_valid = dbg_valid_q;
  assign dbg_addr  = dbg_addr_q;
  assign dbg_data  = dbg_data_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed plan plus random
// traffic against a register/busy array reference model.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0, wr_en = 1'b0, iss_en = 1'b0;
  logic         flush = 1'b0;
  logic [4:0]   wr_addr = '0, iss_rd = '0, ra0 = '0, ra1 = '0;
  logic [63:0]  wr_data = '0;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_busy;
  logic         iss_ready, dbg_valid;
  logic [4:0]   dbg_addr;
  logic [63:0]  dbg_data;

  assign rd_addr = {ra1, ra0};

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .flush     (flush),
    .dbg_valid (dbg_valid),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  typedef struct {
    bit          chk;
    logic [63:0] d0, d1;
    logic [1:0]  b;
    logic        rdy, dv;
    logic [4:0]  da;
    logic [63:0] dd;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mreg [32];
  bit          mbusy [32];
  bit          mdv;
  logic [4:0]  mda;
  logic [63:0] mdd;
  bit          known = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] m_rd(input logic [4:0] a);
    if (a == 0) return 64'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return mreg[a];
  endfunction

  function automatic bit m_busy(input logic [4:0] a);
    return mbusy[a] && !(wr_en && wr_addr == a);
  endfunction

  function automatic bit m_ready(input logic [4:0] a);
    return !mbusy[a] || (wr_en && wr_addr == a) || a == 0;
  endfunction

  task automatic drive(input bit r, input bit we,
                       input logic [4:0] wa,
                       input logic [63:0] wd,
                       input bit ie, input logic [4:0] ir,
                       input bit fl,
                       input logic [4:0] a0,
                       input logic [4:0] a1);
    exp_t e;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_rd = ir; flush = fl;
    ra0 = a0; ra1 = a1;
    e.chk = known;
    e.d0  = m_rd(a0);
    e.d1  = m_rd(a1);
    e.b   = {m_busy(a1), m_busy(a0)};
    e.rdy = m_ready(ir);
    e.dv  = mdv;
    e.da  = mda;
    e.dd  = mdd;
    q.push_back(e);
  endtask

  task automatic step();
    bit legal;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mreg[i] = '0;
        mbusy[i] = 1'b0;
      end
      mdv = 1'b0; mda = '0; mdd = '0;
      known = 1'b1;
    end else begin
      legal = wr_en && wr_addr != 0;
      if (flush) begin
        for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
      end else begin
        if (wr_en) mbusy[wr_addr] = 1'b0;
        if (iss_en && iss_rd != 0) mbusy[iss_rd] = 1'b1;
      end
      if (legal) begin
        mreg[wr_addr] = wr_data;
        mda = wr_addr;
        mdd = wr_data;
      end
      mdv = legal;
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] a0,
                      input logic [4:0] a1,
                      input logic [4:0] ir);
    drive(0, 0, 0, 0, 0, ir, 0, a0, a1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        chk("rd_data0", rd_data[63:0], e.d0);
        chk("rd_data1", rd_data[127:64], e.d1);
        chk("rd_busy", {62'd0, rd_busy}, {62'd0, e.b});
        chk("iss_ready", {63'd0, iss_ready}, {63'd0, e.rdy});
        chk("dbg_valid", {63'd0, dbg_valid}, {63'd0, e.dv});
        chk("dbg_addr", {59'd0, dbg_addr}, {59'd0, e.da});
        chk("dbg_data", dbg_data, e.dd);
      end
      if (iss_en)
        chk("protocol_iss", {63'd0, iss_ready}, 64'd1);
    end
  end

  initial begin
    logic [4:0]  wa, ir;
    logic [63:0] wd;
    bit          we, ie, fl, r;

    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
    for (int a = 0; a < 32; a++) begin
      idle(5'(a), 5'(a), 5'(a)); step();
    end

    drive(0, 1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 5, 0);
    #1 chk("bypass", rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    step();
    idle(5, 5, 0);
    #1 chk("readback", rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    chk("dbg_addr5", {59'd0, dbg_addr}, 64'd5);
    step();

    drive(0, 1, 0, '1, 1, 0, 0, 0, 0);
    #1 chk("r0_bypass", rd_data[63:0], 64'd0);
    step();
    idle(0, 0, 0);
    #1 chk("r0_dbg", {63'd0, dbg_valid}, 64'd0);
    chk("r0_ready", {63'd0, iss_ready}, 64'd1);
    step();

    drive(0, 0, 0, 0, 1, 7, 0, 7, 7); step();
    idle(7, 7, 7);
    #1 chk("busy7", {63'd0, rd_busy[0]}, 64'd1);
    chk("ready7", {63'd0, iss_ready}, 64'd0);
    step();
    drive(0, 1, 7, 64'h77, 0, 7, 0, 7, 7);
    #1 chk("busy7_wb", {63'd0, rd_busy[0]}, 64'd0);
    chk("ready7_wb", {63'd0, iss_ready}, 64'd1);
    step();
    idle(7, 7, 7); step();

    drive(0, 0, 0, 0, 1, 9, 0, 9, 9); step();
    drive(0, 1, 9, 64'h99, 1, 9, 0, 9, 9); step();
    idle(9, 9, 9);
    #1 chk("busy9_kept", {63'd0, rd_busy[0]}, 64'd1);
    chk("reg9", rd_data[63:0], 64'h99);
    step();

    for (int i = 3; i <= 5; i++) begin
      drive(0, 0, 0, 0, 1, 5'(i), 0, 3, 4); step();
    end
    drive(0, 0, 0, 0, 1, 6, 1, 3, 5); step();
    idle(6, 4, 6);
    #1 chk("flush6", {62'd0, rd_busy}, 64'd0);
    step();
    drive(0, 1, 10, 64'hA0A0, 0, 0, 0, 10, 0); step();
    drive(1, 1, 10, 64'h1234, 0, 0, 0, 10, 0); step();
    idle(10, 10, 0);
    #1 chk("rst_prio", rd_data[63:0], 64'd0);
    step();

    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 29) == 0);
      we = $urandom_range(0, 1);
      wa = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      ir = 5'($urandom_range(0, 31));
      wr_en = we; wr_addr = wa;
      ie = ($urandom_range(0, 2) != 0) && m_ready(ir);
      drive(r, we, wa, wd, ie, ir, fl,
            5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? wa
                                        : 5'($urandom_range(0, 31)));
      step();
    end

    idle(0, 0, 0);
    step();
    #10;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
